// File: rtl/comp_serial_mag_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM encoding and
// the registered result-flag bundle.
package comp_serial_mag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } flags_t;

    localparam flags_t FLAGS_NONE = '{gt: 1'b0, lt: 1'b0, eq: 1'b0};
    localparam flags_t FLAGS_GT   = '{gt: 1'b1, lt: 1'b0, eq: 1'b0};
    localparam flags_t FLAGS_LT   = '{gt: 1'b0, lt: 1'b1, eq: 1'b0};
    localparam flags_t FLAGS_EQ   = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};

endpackage

// File: rtl/comp_1bit_case.sv
// Single-bit magnitude compare; exactly one of gt/lt/eq is high.
module comp_1bit_case (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);

    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        eq = 1'b0;
        case ({a, b})
            2'b10:   gt = 1'b1;
            2'b01:   lt = 1'b1;
            default: eq = 1'b1;
        endcase
    end

endmodule

// File: rtl/comp_serial_mag.sv
// Bit-serial unsigned magnitude comparator, MSB first, with early exit on the
// first differing bit. Result flags and done are registered.
module comp_serial_mag
    import comp_serial_mag_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    flags_t           res_q, res_d;
    flags_t           flg_q, flg_d;
    logic             done_q, done_d;

    logic bit_gt, bit_lt, bit_eq;

    comp_1bit_case u_bit_cmp (
        .a  (sa_q[WIDTH-1]),
        .b  (sb_q[WIDTH-1]),
        .gt (bit_gt),
        .lt (bit_lt),
        .eq (bit_eq)
    );

    // ST_DONE is the commit cycle: the decided result moves to the visible
    // flags together with the done pulse, so flags never lead done. start is
    // therefore taken in ST_IDLE, which is also the cycle done is high.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flg_d   = flg_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a_in;
                    sb_d    = b_in;
                    cnt_d   = CW'(WIDTH - 1);
                    res_d   = FLAGS_NONE;
                    flg_d   = FLAGS_NONE;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bit_gt) begin
                    res_d   = FLAGS_GT;
                    state_d = ST_DONE;
                end else if (bit_lt) begin
                    res_d   = FLAGS_LT;
                    state_d = ST_DONE;
                end else if (bit_eq && cnt_q == '0) begin
                    res_d   = FLAGS_EQ;
                    state_d = ST_DONE;
                end else begin
                    // fill bit is 0 and never reaches the compare point
                    sa_d  = {sa_q[WIDTH-2:0], 1'b0};
                    sb_d  = {sb_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                flg_d   = res_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            res_q   <= FLAGS_NONE;
            flg_q   <= FLAGS_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign gt   = flg_q.gt;
    assign lt   = flg_q.lt;
    assign eq   = flg_q.eq;

endmodule

// File: tb/tb_comp_serial_mag.sv
// Directed bench for comp_serial_mag (WIDTH=4): latency, flags, handshake,
// back-to-back start and reset behaviour against hand-computed expectations.
module tb_comp_serial_mag;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy, done, gt, lt, eq;

    int n_cmp = 0;
    int n_err = 0;

    comp_serial_mag #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .lt    (lt),
        .eq    (eq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
    endtask

    // Waits for the accepting edge, then for done; returns sampled in the done cycle.
    task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int exp_lat, input bit poke);
        int lat    = 0;
        int busy_n = 0;
        bit leak   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        if (busy) busy_n++;
        if (gt | lt | eq | done) leak = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (poke && k == 2) begin
                start = 1'b1;
                a_in  = 4'hF;
                b_in  = 4'h0;
            end
            @(posedge clk); #1;
            if (poke && k == 2) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_n++;
            if (gt | lt | eq) leak = 1'b1;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".busy_cycles"}, busy_n, exp_lat - 1);
        chk({tag, ".flags_early"}, {31'd0, leak}, 0);
        chk({tag, ".gt"}, {31'd0, gt}, {31'd0, a > b});
        chk({tag, ".lt"}, {31'd0, lt}, {31'd0, a < b});
        chk({tag, ".eq"}, {31'd0, eq}, {31'd0, a == b});
        chk({tag, ".onehot"}, 32'(gt) + 32'(lt) + 32'(eq), 1);
    endtask

    initial begin
        bit saw_done;

        // 1: async reset with the clock low, mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("rst.busy", {31'd0, busy}, 0);
        chk("rst.done", {31'd0, done}, 0);
        chk("rst.flags", {29'd0, gt, lt, eq}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle.busy", {31'd0, busy}, 0);

        // 2: MSBs differ -> minimum latency
        @(negedge clk); launch(4'b1000, 4'b0111);
        wait_result("t2", 4'b1000, 4'b0111, 2, 1'b0);
        @(posedge clk); #1;
        chk("t2.done_pulse", {31'd0, done}, 0);
        chk("t2.gt_hold", {31'd0, gt}, 1);

        // extra patterns: mid-word mismatch and MSB lt
        @(negedge clk); launch(4'b1101, 4'b1011);
        wait_result("gt_mid", 4'b1101, 4'b1011, 3, 1'b0);
        @(negedge clk); launch(4'b0000, 4'b1111);
        wait_result("lt_msb", 4'b0000, 4'b1111, 2, 1'b0);

        // 3: LSB decides
        @(negedge clk); launch(4'b0110, 4'b0111);
        wait_result("t3", 4'b0110, 4'b0111, 5, 1'b0);

        // 4: equal operands, flags held afterwards
        @(negedge clk); launch(4'b1010, 4'b1010);
        wait_result("t4", 4'b1010, 4'b1010, 5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4.eq_hold", {31'd0, eq}, 1);
        chk("t4.done_low", {31'd0, done}, 0);

        // 5: start while busy ignored, then back-to-back start in the done cycle
        @(negedge clk); launch(4'b0110, 4'b0111);
        wait_result("t5", 4'b0110, 4'b0111, 5, 1'b1);
        launch(4'b1001, 4'b1100);
        wait_result("t5b2b", 4'b1001, 4'b1100, 3, 1'b0);

        // 6: reset during RUN discards the comparison
        @(negedge clk); launch(4'b0110, 4'b0111);
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6.rst_busy", {31'd0, busy}, 0);
        chk("t6.rst_flags", {29'd0, gt, lt, eq}, 0);
        @(negedge clk) rst = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("t6.no_done", {31'd0, saw_done}, 0);
        @(negedge clk); launch(4'b0001, 4'b0001);
        wait_result("t6eq", 4'b0001, 4'b0001, 5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
